heartbeat_supervisor: RTL and testbench
=======================================

Name: heartbeat_supervisor

Overview:
Generates the `heartbeat` kick that feeds `watchdog_timer`. It kicks only when every monitored datapath source has shown activity within the current kick window. A stalled source therefore withholds kicks, and the watchdog times out. The block also reacts to the watchdog's `warning` (early kick when healthy) and `force_reset` (hold-off, then clean restart). It sits between the AM-radio datapath strobes and the watchdog, in the same clock domain.

Parameters:
- N_SRC, 4: number of monitored activity sources.
- KICK_PERIOD, 1000: cycles per kick window in RUN (≥2).
- HOLDOFF, 16: cycles of silence after reset, enable rise or `force_reset` (≥1).
- CNT_W, 16: width of `kick_count`.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  supervisor enable; level.
- alive  in  N_SRC  per-source activity strobe; any-width pulse, sampled each cycle.
- wd_warning  in  1  watchdog near-expiry indication; level.
- wd_force_reset  in  1  watchdog bite; level or pulse.
- heartbeat  out  1  registered one-cycle kick to the watchdog.
- src_stale  out  N_SRC  latched per-source stale flags from the last failed window.
- state  out  2  FSM state encoding: IDLE=0, HOLDOFF=1, RUN=2, STALL=3.
- kick_count  out  CNT_W  saturating count of heartbeats issued.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; heartbeat=0; src_stale=0; kick_count=0.
  - Internal seen[]=0; period counter=0; hold-off counter=0.
- Accumulation: seen_next = seen | alive every cycle. An alive pulse in an evaluation cycle counts toward that evaluation.
- IDLE:
  - No kicks; seen held at 0.
  - enable=1 → HOLDOFF, with the hold-off counter loaded to 0.
- HOLDOFF:
  - No kicks; seen accumulates.
  - After exactly HOLDOFF cycles in HOLDOFF → RUN, with the period counter set to 0.
- RUN:
  - The period counter increments each cycle.
  - Evaluation fires at count KICK_PERIOD-1, or early on any cycle where wd_warning=1 and seen_next is all ones.
  - Evaluation with seen_next all ones:
    - heartbeat=1 next cycle, for exactly one cycle.
    - seen cleared; period counter reset to 0; src_stale cleared.
    - kick_count increments, saturating at 2^CNT_W-1.
  - Evaluation at KICK_PERIOD-1 with any bit missing:
    - No kick.
    - src_stale latched to ~seen_next.
    - Move to STALL; seen is not cleared.
- STALL:
  - No periodic kicks; seen keeps accumulating.
  - On the first cycle where seen_next is all ones:
    - heartbeat pulse next cycle; seen cleared; src_stale cleared.
    - kick_count increments; → RUN with the period counter at 0.
  - While stalled, src_stale additionally ORs in nothing. It holds the latched value until recovery.
- wd_force_reset=1 in any non-IDLE state:
  - → HOLDOFF; seen cleared; period counter cleared; heartbeat forced 0 next cycle.
  - src_stale and kick_count are retained for diagnosis.
  - If wd_force_reset stays high, the block stays in HOLDOFF with the hold-off counter held at 0.
- enable=0 in any state:
  - → IDLE next cycle; seen cleared; heartbeat=0.
  - src_stale and kick_count retained.
  - Priority: rstn > enable=0 > wd_force_reset > evaluation.
- Heartbeat spacing: two heartbeats are never back-to-back. An evaluation cannot fire in the cycle immediately after a kick, because the period counter was just cleared and early kick requires a fresh, full seen_next from that cycle onward.
- Width rules: all counters use $clog2 of their bound, minimum 1 bit. No wrap-around of kick_count.

Decomposition:
- Shared package `wd_pkg`:
  - State enum for IDLE, HOLDOFF, RUN, STALL with its 2-bit encoding.
  - Default KICK_PERIOD and HOLDOFF constants, also shared with the watchdog_timer configuration, so the kick period is always below the timeout.
- Sub-module `activity_latch`:
  - One instance per source in a generate loop.
  - Holds the seen bit with set (alive), clear (kick, force_reset or disable) and stale-capture.
  - The FSM and counters stay in the top.

Test Plan (N_SRC=2, KICK_PERIOD=8, HOLDOFF=4, CNT_W=4):
1. Reset sequence with rstn released at cycle 0 and enable=1 → cycles 0–3 have state=HOLDOFF, cycle 4 enters RUN; heartbeat stays 0 throughout and kick_count=0.
2. Healthy run: alive=2'b11 pulsed every 3 cycles → heartbeat exactly 8 cycles after RUN entry and every 8 cycles after that; kick_count reaches 15 and saturates.
3. Stale source: alive[1] never pulses → no heartbeat; at end of the window state=STALL and src_stale=2'b10; a later alive[1] pulse → heartbeat next cycle, state=RUN and src_stale=0.
4. Early kick: both seen, then wd_warning=1 at period count 3 → heartbeat next cycle and period counter restarts. With wd_warning=1 but only alive[0] seen → no kick.
5. Bite mid-window: wd_force_reset pulse in RUN at count 5 → HOLDOFF for 4 cycles and seen cleared; kick_count and src_stale unchanged; first kick comes 8 cycles after RUN re-entry.
6. Async reset while heartbeat=1 and state=STALL → all outputs 0 and state=IDLE immediately, without waiting for a clock edge. Dropping enable in RUN → IDLE next cycle with no kick.

Source files
------------

// File: rtl/wd_pkg.sv
// Shared definitions for the heartbeat supervisor and the watchdog configuration.
// The default kick period and hold-off live here so the watchdog timeout can be
// derived from the same numbers and always stays longer than one kick window.
package wd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLDOFF = 2'd1,
      ST_RUN     = 2'd2,
      ST_STALL   = 2'd3
   } sup_state_e;

   localparam int DEF_KICK_PERIOD = 1000;
   localparam int DEF_HOLDOFF     = 16;

   // Counter width for a count that runs from 0 to bound-1, never narrower than one bit.
   function automatic int cnt_width(input int bound);
      return (bound > 1) ? $clog2(bound) : 1;
   endfunction

endpackage

// File: rtl/activity_latch.sv
// Per-source activity latch: remembers whether its source strobed during the
// current kick window and keeps the stale flag from the last failed window.
module activity_latch (
   input  logic clk,
   input  logic rstn,
   input  logic alive,
   input  logic clear,
   input  logic capture,
   input  logic stale_clear,
   output logic seen_next,
   output logic stale
);

   logic seen;

   assign seen_next = seen | alive;

   // Seen bit accumulates strobes until a kick, a watchdog bite or a disable wipes it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         seen <= 1'b0;
      end else if (clear) begin
         seen <= 1'b0;
      end else begin
         seen <= seen_next;
      end
   end

   // Stale flag is captured when a window fails and dropped again on the recovery kick.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stale <= 1'b0;
      end else if (capture) begin
         stale <= ~seen_next;
      end else if (stale_clear) begin
         stale <= 1'b0;
      end
   end

endmodule

// File: rtl/heartbeat_supervisor.sv
// Heartbeat supervisor: kicks the watchdog only while every monitored datapath
// source shows activity inside each kick window. A stalled source withholds
// kicks so the watchdog eventually bites; a bite forces a fresh hold-off.
module heartbeat_supervisor
   import wd_pkg::*;
#(
   parameter int N_SRC       = 4,
   parameter int KICK_PERIOD = DEF_KICK_PERIOD,
   parameter int HOLDOFF     = DEF_HOLDOFF,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic [N_SRC-1:0] alive,
   input  logic             wd_warning,
   input  logic             wd_force_reset,
   output logic             heartbeat,
   output logic [N_SRC-1:0] src_stale,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] kick_count
);

   localparam int PW = cnt_width(KICK_PERIOD);
   localparam int HW = cnt_width(HOLDOFF);
   localparam logic [PW-1:0]    PERIOD_LAST = PW'(KICK_PERIOD - 1);
   localparam logic [HW-1:0]    HOLD_LAST   = HW'(HOLDOFF - 1);
   localparam logic [CNT_W-1:0] KICK_MAX    = '1;

   sup_state_e       state_q, state_d;
   logic [PW-1:0]    period_q, period_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [N_SRC-1:0] seen_next;
   logic             all_seen;
   logic             kick;
   logic             seen_clear;
   logic             stale_capture;
   logic             stale_clear;

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      activity_latch u_latch (
         .clk         (clk),
         .rstn        (rstn),
         .alive       (alive[i]),
         .clear       (seen_clear),
         .capture     (stale_capture),
         .stale_clear (stale_clear),
         .seen_next   (seen_next[i]),
         .stale       (src_stale[i])
      );
   end

   assign all_seen = &seen_next;
   assign state    = state_q;

   // State, window counters, the registered kick and the saturating kick tally.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         period_q   <= '0;
         hold_q     <= '0;
         heartbeat  <= 1'b0;
         kick_count <= '0;
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         hold_q    <= hold_d;
         heartbeat <= kick;
         if (kick && (kick_count != KICK_MAX)) begin
            kick_count <= kick_count + 1'b1;
         end
      end
   end

   // Next-state logic: disable beats a bite, a bite beats window evaluation.
   // Evaluation is suppressed in the cycle right after a kick so kicks never abut.
   always_comb begin
      state_d       = state_q;
      period_d      = period_q;
      hold_d        = hold_q;
      kick          = 1'b0;
      seen_clear    = 1'b0;
      stale_capture = 1'b0;
      stale_clear   = 1'b0;

      if (!enable) begin
         state_d    = ST_IDLE;
         period_d   = '0;
         hold_d     = '0;
         seen_clear = 1'b1;
      end else if (wd_force_reset && (state_q != ST_IDLE)) begin
         state_d    = ST_HOLDOFF;
         period_d   = '0;
         hold_d     = '0;
         seen_clear = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               seen_clear = 1'b1;
               state_d    = ST_HOLDOFF;
               hold_d     = '0;
               period_d   = '0;
            end
            ST_HOLDOFF: begin
               if (hold_q == HOLD_LAST) begin
                  state_d  = ST_RUN;
                  period_d = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (!heartbeat && all_seen && ((period_q == PERIOD_LAST) || wd_warning)) begin
                  kick        = 1'b1;
                  period_d    = '0;
                  seen_clear  = 1'b1;
                  stale_clear = 1'b1;
               end else if (period_q == PERIOD_LAST) begin
                  state_d       = ST_STALL;
                  stale_capture = 1'b1;
                  period_d      = '0;
               end else begin
                  period_d = period_q + 1'b1;
               end
            end
            ST_STALL: begin
               if (all_seen) begin
                  kick        = 1'b1;
                  state_d     = ST_RUN;
                  period_d    = '0;
                  seen_clear  = 1'b1;
                  stale_clear = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_heartbeat_supervisor.sv
// Bench for heartbeat_supervisor: directed walk through the main scenarios with
// hand-computed expectations, then randomized traffic checked every cycle
// against a window/deadline model of the supervisor.
module tb_heartbeat_supervisor;

   localparam int N_SRC       = 2;
   localparam int KICK_PERIOD = 8;
   localparam int HOLDOFF     = 4;
   localparam int CNT_W       = 4;
   localparam int ALL_SEEN    = (1 << N_SRC) - 1;
   localparam int KICK_MAX    = (1 << CNT_W) - 1;

   logic             clk;
   logic             rstn;
   logic             enable;
   logic [N_SRC-1:0] alive;
   logic             wd_warning;
   logic             wd_force_reset;
   logic             heartbeat;
   logic [N_SRC-1:0] src_stale;
   logic [1:0]       state;
   logic [CNT_W-1:0] kick_count;

   int n_compared   = 0;
   int n_mismatched = 0;
   bit cmp_en       = 1'b0;

   // Model: mode uses the published output codes 0..3; windows are tracked as
   // absolute clock-edge deadlines rather than running counters.
   int     m_mode   = 0;
   int     m_seen   = 0;
   int     m_stale  = 0;
   int     m_kicks  = 0;
   bit     m_hb     = 1'b0;
   longint cyc      = 0;
   longint run_at   = 0;
   longint deadline = 0;

   heartbeat_supervisor #(
      .N_SRC       (N_SRC),
      .KICK_PERIOD (KICK_PERIOD),
      .HOLDOFF     (HOLDOFF),
      .CNT_W       (CNT_W)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .enable         (enable),
      .alive          (alive),
      .wd_warning     (wd_warning),
      .wd_force_reset (wd_force_reset),
      .heartbeat      (heartbeat),
      .src_stale      (src_stale),
      .state          (state),
      .kick_count     (kick_count)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_compared++;
      if (actual != expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [N_SRC-1:0] al, input logic warn, input logic bite);
      enable         = en;
      alive          = al;
      wd_warning     = warn;
      wd_force_reset = bite;
   endtask

   task automatic waitState(input int target, input int budget, input string name);
      int t;
      t = 0;
      while ((t < budget) && (int'(state) != target)) begin
         @(negedge clk);
         t++;
      end
      checkOutput(name, int'(state), target);
   endtask

   task automatic modelReset();
      m_mode  = 0;
      m_seen  = 0;
      m_stale = 0;
      m_kicks = 0;
      m_hb    = 1'b0;
   endtask

   task automatic modelStep();
      int now_seen;
      bit full;
      bit kick;
      cyc      = cyc + 1;
      now_seen = m_seen | int'(alive);
      full     = (now_seen == ALL_SEEN);
      kick     = 1'b0;
      if (!enable) begin
         m_mode = 0;
         m_seen = 0;
      end else if (wd_force_reset && (m_mode != 0)) begin
         m_mode = 1;
         m_seen = 0;
         run_at = cyc + HOLDOFF;
      end else if (m_mode == 0) begin
         m_mode = 1;
         m_seen = 0;
         run_at = cyc + HOLDOFF;
      end else if (m_mode == 1) begin
         m_seen = now_seen;
         if (cyc == run_at) begin
            m_mode   = 2;
            deadline = cyc + KICK_PERIOD;
         end
      end else if (m_mode == 2) begin
         if (full && !m_hb && ((cyc == deadline) || wd_warning)) begin
            kick = 1'b1;
         end else if (cyc == deadline) begin
            m_mode  = 3;
            m_stale = ~now_seen & ALL_SEEN;
            m_seen  = now_seen;
         end else begin
            m_seen = now_seen;
         end
      end else begin
         if (full) kick = 1'b1;
         else m_seen = now_seen;
      end
      if (kick) begin
         m_mode   = 2;
         m_seen   = 0;
         m_stale  = 0;
         deadline = cyc + KICK_PERIOD;
         if (m_kicks < KICK_MAX) m_kicks++;
      end
      m_hb = kick;
   endtask

   // Model advances on every clock edge and resets asynchronously with the DUT.
   initial begin
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) modelReset();
         else modelStep();
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            checkOutput("model_state", int'(state), m_mode);
            checkOutput("model_heartbeat", int'(heartbeat), int'(m_hb));
            checkOutput("model_src_stale", int'(src_stale), m_stale);
            checkOutput("model_kick_count", int'(kick_count), m_kicks);
         end
      end
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      rstn = 1'b0;
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      checkOutput("reset_state", int'(state), 0);
      checkOutput("reset_heartbeat", int'(heartbeat), 0);
      checkOutput("reset_src_stale", int'(src_stale), 0);
      checkOutput("reset_kick_count", int'(kick_count), 0);

      // Release reset with enable high: four hold-off cycles, then RUN.
      rstn = 1'b1;
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("holdoff_state", int'(state), 1);
         checkOutput("holdoff_heartbeat", int'(heartbeat), 0);
         checkOutput("holdoff_kick_count", int'(kick_count), 0);
      end
      @(negedge clk);
      checkOutput("run_entry_state", int'(state), 2);
      checkOutput("run_entry_heartbeat", int'(heartbeat), 0);

      // Healthy traffic every third cycle: one kick per 8 cycles until saturation.
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      for (int j = 1; j <= 144; j++) begin
         @(negedge clk);
         checkOutput("healthy_heartbeat", int'(heartbeat), ((j % 8) == 0) ? 1 : 0);
         checkOutput("healthy_kick_count", int'(kick_count), ((j / 8) < KICK_MAX) ? (j / 8) : KICK_MAX);
         applyStimulus(1'b1, (((j % 3) == 0) && (j < 144)) ? 2'b11 : 2'b00, 1'b0, 1'b0);
      end
      checkOutput("kick_count_saturated", int'(kick_count), 15);

      // Source 1 silent: window fails into STALL, then recovers on its strobe.
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         checkOutput("stale_run_state", int'(state), 2);
         checkOutput("stale_no_kick", int'(heartbeat), 0);
         applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      end
      @(negedge clk);
      checkOutput("stall_state", int'(state), 3);
      checkOutput("stall_src_stale", int'(src_stale), 2);
      checkOutput("stall_no_kick", int'(heartbeat), 0);
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      for (int k = 9; k <= 11; k++) begin
         @(negedge clk);
         checkOutput("stall_hold_state", int'(state), 3);
         checkOutput("stall_hold_stale", int'(src_stale), 2);
         checkOutput("stall_hold_no_kick", int'(heartbeat), 0);
         applyStimulus(1'b1, (k == 11) ? 2'b10 : 2'b01, 1'b0, 1'b0);
      end
      @(negedge clk);
      checkOutput("recover_heartbeat", int'(heartbeat), 1);
      checkOutput("recover_state", int'(state), 2);
      checkOutput("recover_src_stale", int'(src_stale), 0);
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);

      // Early kick: both sources seen, warning raised at period count 3.
      for (int k = 13; k <= 15; k++) begin
         @(negedge clk);
         checkOutput("early_pre_no_kick", int'(heartbeat), 0);
         applyStimulus(1'b1, 2'b00, (k == 15) ? 1'b1 : 1'b0, 1'b0);
      end
      @(negedge clk);
      checkOutput("early_kick_heartbeat", int'(heartbeat), 1);
      checkOutput("early_kick_state", int'(state), 2);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
      for (int k = 17; k <= 21; k++) begin
         @(negedge clk);
         checkOutput("warning_partial_no_kick", int'(heartbeat), 0);
         if (k == 21) applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
         else applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
      end

      // Bite at period count 5: fresh hold-off, then a full window before the kick.
      @(negedge clk);
      checkOutput("bite_state", int'(state), 1);
      checkOutput("bite_src_stale", int'(src_stale), 0);
      checkOutput("bite_kick_count", int'(kick_count), 15);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      for (int k = 23; k <= 25; k++) begin
         @(negedge clk);
         checkOutput("bite_holdoff_state", int'(state), 1);
         checkOutput("bite_holdoff_no_kick", int'(heartbeat), 0);
      end
      @(negedge clk);
      checkOutput("bite_run_reentry", int'(state), 2);
      for (int k = 27; k <= 33; k++) begin
         @(negedge clk);
         checkOutput("bite_window_no_kick", int'(heartbeat), 0);
         applyStimulus(1'b1, (k == 28) ? 2'b11 : 2'b00, 1'b0, 1'b0);
      end
      @(negedge clk);
      checkOutput("bite_first_kick", int'(heartbeat), 1);

      // Asynchronous reset while the heartbeat is high.
      #2 rstn = 1'b0;
      #1;
      checkOutput("async_hb_state", int'(state), 0);
      checkOutput("async_hb_heartbeat", int'(heartbeat), 0);
      checkOutput("async_hb_kick_count", int'(kick_count), 0);

      // Asynchronous reset while stalled clears the latched stale flags.
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      waitState(3, 40, "reach_stall");
      checkOutput("pre_reset_src_stale", int'(src_stale), 2);
      #2 rstn = 1'b0;
      #1;
      checkOutput("async_stall_state", int'(state), 0);
      checkOutput("async_stall_src_stale", int'(src_stale), 0);

      // Dropping enable on the evaluation cycle returns to IDLE without a kick.
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      waitState(2, 20, "reach_run");
      repeat (7) @(negedge clk);
      applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("disable_state", int'(state), 0);
      checkOutput("disable_no_kick", int'(heartbeat), 0);
      checkOutput("disable_kick_count", int'(kick_count), 0);

      // Randomized traffic with rare disables, bites and resets.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         rstn = ($urandom_range(0, 499) != 0);
         applyStimulus(($urandom_range(0, 199) != 0),
                       {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)},
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 149) == 0));
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
